stream_demux4: RTL and testbench
================================

Name: stream_demux4

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the team's 4:1 multiplexer.
- Accepts a single valid/ready stream of WIDTH-bit words, each tagged with a 2-bit destination address (addr1:addr0).
- Delivers each word to one of four output channels, each through its own one-entry holding slot.
- Keeps a saturating per-channel count of delivered words.
- Sits between a shared producer and four independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- addr0  input  1  destination address bit 0.
- addr1  input  1  destination address bit 1.
- in_valid  input  1  producer has a word on in_data/addr.
- in_ready  output  1  demux accepts the word this cycle.
- out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- out_valid  output  4  bit k: channel k slot holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- count  output  4*CNT_W  channel k delivered count at [k*CNT_W +: CNT_W].

Behaviour:
- Destination index sel = {addr1, addr0}: 00 goes to ch0, 01 to ch1, 10 to ch2, 11 to ch3.
- Reset (sampled at clk edge while reset=1):
  - all slots empty; out_valid=0000.
  - out_data=0.
  - all counters 0.
  - in_ready then follows the combinational rule below, so it is 1 the cycle after reset deasserts.
  - Reset mid-transfer discards slot contents with no output handshake.
- Slot state machine per channel: EMPTY and FULL.
  - EMPTY to FULL: accept for this channel.
  - FULL to EMPTY: out_valid[k]&out_ready[k] with no new accept for k.
  - FULL to FULL: drain and accept for k in the same cycle. The new word replaces the old one, giving a back-to-back throughput of 1 word/cycle/channel.
- in_ready (combinational) = slot[sel] EMPTY, or slot[sel] drained this cycle (out_ready[sel]=1).
  - Depends only on sel and the state/out_ready of that one channel.
  - Other channels stalling never block traffic to a free channel.
- Accept = in_valid & in_ready. The word is latched into slot[sel] at that edge.
- Latency: out_valid[sel]=1 and out_data=word on the cycle after accept (1 cycle).
- out_data for a channel holds stable while FULL and not drained. Its value is don't-care while EMPTY, but the implementation retains the last word.
- Producer rule: in_data/addr held stable while in_valid=1 and in_ready=0. in_valid is not withdrawn before accept. The bench checks this on the producer side.
- Counters:
  - count[k] increments by 1 on each output handshake of channel k.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - Drain on ch j and accept to ch k≠j in the same cycle are independent.
  - Drain and accept on the same channel are handled per the FULL to FULL transition.
- No internal reordering is possible. Order is preserved per channel.
- Outputs are X-free after the first reset.

Decomposition:
- Shared package stream_demux_pkg:
  - NUM_CH=4.
  - SEL_W=2.
  - channel index constants CH0..CH3.
  - slot state encoding (EMPTY=0, FULL=1).
- Natural sub-module demux_slot, instantiated 4×:
  - one-entry valid/ready register with load, drain and "can_accept" outputs.
  - saturating CNT_W counter.
- Top level does address decode, in_ready select and port packing.

Test Plan:
- Reset then single word: reset 2 cycles; in_data=8'hA5, addr=10, in_valid 1 cycle, out_ready=1111 → next cycle out_valid=0100 and ch2 data=A5; following cycle out_valid=0000; count2=1, others 0.
- Full-slot backpressure: out_ready=0000; send 8'h11 to ch1 and accept. Then present 8'h22 to ch1 → in_ready=0 and ch1 holds 11. Raise out_ready[1] → 22 is accepted the same cycle and visible next cycle; count1=1, then 2 after its drain.
- Independent channels: ch0 FULL with out_ready[0]=0; send 8'h33 to ch3 → in_ready=1, accepted, out_valid=1001.
- Streaming: out_ready=1111; 16 consecutive words 0..15 with addr=i mod 4, in_valid held high → in_ready stays 1 for all 16; each channel receives its 4 words in order; each count=4.
- Counter saturation with CNT_W=3: 9 handshakes on ch0 → count0 reads 7 after the 7th, 8th and 9th.
- Reset mid-operation: all four slots FULL, assert reset 1 cycle → out_valid=0000, counts=0, no output handshake during or after reset.

Source files
------------

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// stream_demux_pkg : shared constants and slot state type for stream_demux4
// Rev 1.0
// ============================================================================
package stream_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// demux_slot : one-entry valid/ready holding slot with saturating drain count
// Rev 1.0
// ============================================================================
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_out_ready,
    output logic             o_can_accept,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    slot_state_t      r_state_q, w_state_d;
    logic [WIDTH-1:0] r_data_q,  w_data_d;
    logic [CNT_W-1:0] r_count_q, w_count_d;
    logic             w_drain;

    assign w_drain      = (r_state_q == SLOT_FULL) && i_out_ready;
    // A full slot that drains this cycle frees its entry for a same-cycle load.
    assign o_can_accept = (r_state_q == SLOT_EMPTY) || i_out_ready;
    assign o_valid      = (r_state_q == SLOT_FULL);
    assign o_data       = r_data_q;
    assign o_count      = r_count_q;

    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_count_d = r_count_q;
        if (i_load) begin
            w_state_d = SLOT_FULL;
            w_data_d  = i_data;
        end else if (w_drain) begin
            w_state_d = SLOT_EMPTY;
        end
        if (w_drain && (r_count_q != c_CNT_MAX)) begin
            w_count_d = r_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= SLOT_EMPTY;
            r_data_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_count_q <= w_count_d;
        end
    end

endmodule : demux_slot
`default_nettype wire

// File: rtl/stream_demux4.sv
`default_nettype none
// ============================================================================
// stream_demux4 : registered 1-to-4 valid/ready stream demultiplexer
// Rev 1.0
// ============================================================================
module stream_demux4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    addr0,
    input  logic                    addr1,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*CNT_W-1:0] count
);

    logic [SEL_W-1:0]  w_sel;
    logic [NUM_CH-1:0] w_can_accept;
    logic [NUM_CH-1:0] w_load;
    logic              w_accept;

    assign w_sel    = {addr1, addr0};
    // Only the addressed channel gates the producer; stalled channels elsewhere are irrelevant.
    assign in_ready = w_can_accept[w_sel];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_load        = '0;
        w_load[w_sel] = w_accept;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .i_load       (w_load[k]),
            .i_data       (in_data),
            .i_out_ready  (out_ready[k]),
            .o_can_accept (w_can_accept[k]),
            .o_valid      (out_valid[k]),
            .o_data       (out_data[k*WIDTH +: WIDTH]),
            .o_count      (count[k*CNT_W +: CNT_W])
        );
    end

endmodule : stream_demux4
`default_nettype wire

// File: tb/tb_stream_demux4.sv
`default_nettype none
// ============================================================================
// tb_stream_demux4 : directed self-checking bench for stream_demux4
// Rev 1.0
// ============================================================================
module tb_stream_demux4;
    import stream_demux_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        addr0, addr1, in_valid;
    logic [3:0]  out_ready;
    logic        in_ready,  in_ready_s;
    logic [31:0] out_data,  out_data_s;
    logic [3:0]  out_valid, out_valid_s;
    logic [31:0] count;
    logic [11:0] count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_demux4 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .addr0(addr0), .addr1(addr1),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    stream_demux4 #(.WIDTH(8), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .in_data(in_data), .addr0(addr0), .addr1(addr1),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .count(count_s)
    );

    // Producer-side rule: a stalled word stays presented and unchanged.
    logic       p_stall = 1'b0;
    logic [9:0] p_word;
    always @(posedge clk) begin
        if (!reset && p_stall) begin
            checks++;
            if (!in_valid || {addr1, addr0, in_data} !== p_word) begin
                errors++;
                $display("FAIL producer_hold: got v=%b w=%h, need v=1 w=%h", in_valid, {addr1, addr0, in_data}, p_word);
            end
        end
        p_stall = !reset && in_valid && !in_ready;
        p_word  = {addr1, addr0, in_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [7:0] d);
        {addr1, addr0} = a;
        in_data        = d;
        in_valid       = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        out_ready = 4'b0000; in_data = 8'h00; {addr1, addr0} = CH0;
        do_reset(2);
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b need 0000", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h need 0", out_data); end
        checks++; if (count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h need 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 4'b1111;
        drive(CH2, 8'hA5);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b need 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid: got %b need 0100", out_valid); end
        checks++; if (out_data[23:16] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h need a5", out_data[23:16]); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drained: got %b need 0000", out_valid); end
        checks++; if (count !== 32'h0001_0000) begin errors++; $display("FAIL single_count: got %h need 00010000", count); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b0000;
        drive(CH1, 8'h11);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b need 1", in_ready); end
        tick();
        in_data = 8'h22;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b need 0", in_ready); end
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid: got %b need 0010", out_valid); end
        checks++; if (out_data[15:8] !== 8'h11) begin errors++; $display("FAIL bp_hold: got %h need 11", out_data[15:8]); end
        tick();
        checks++; if (out_data[15:8] !== 8'h11) begin errors++; $display("FAIL bp_hold2: got %h need 11", out_data[15:8]); end
        out_ready = 4'b0010;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b need 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_data[15:8] !== 8'h22) begin errors++; $display("FAIL bp_replace: got %h need 22", out_data[15:8]); end
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_replace_valid: got %b need 0010", out_valid); end
        checks++; if (count[15:8] !== 8'd1) begin errors++; $display("FAIL bp_count1: got %0d need 1", count[15:8]); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_empty: got %b need 0000", out_valid); end
        checks++; if (count[15:8] !== 8'd2) begin errors++; $display("FAIL bp_count2: got %0d need 2", count[15:8]); end
        out_ready = 4'b0000;
    endtask

    task automatic test_independent();
        out_ready = 4'b0000;
        drive(CH0, 8'h44);
        tick();
        drive(CH3, 8'h33);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b need 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1001) begin errors++; $display("FAIL indep_valid: got %b need 1001", out_valid); end
        checks++; if (out_data[31:24] !== 8'h33 || out_data[7:0] !== 8'h44) begin
            errors++; $display("FAIL indep_data: got %h need 33xxxx44", out_data); end
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        checks++; if (count !== 32'h0101_0201) begin errors++; $display("FAIL indep_counts: got %h need 01010201", count); end
    endtask

    task automatic test_streaming();
        do_reset(1);
        out_ready = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            drive(2'(i % 4), 8'(i));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b need 1", i, in_ready); end
            tick();
            checks++; if (out_data[(i%4)*8 +: 8] !== 8'(i) || out_valid[i%4] !== 1'b1) begin
                errors++; $display("FAIL stream_word[%0d]: got %h/%b need %h/1", i, out_data[(i%4)*8 +: 8], out_valid[i%4], 8'(i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (count !== 32'h0404_0404) begin errors++; $display("FAIL stream_counts: got %h need 04040404", count); end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stream_empty: got %b need 0000", out_valid); end
    endtask

    task automatic test_saturation();
        do_reset(1);
        out_ready = 4'b1111;
        for (int e = 1; e <= 10; e++) begin
            if (e <= 9) drive(CH0, 8'(8'hC0 + e)); else in_valid = 1'b0;
            tick();
            checks++; if (count_s[2:0] !== 3'((e - 1 > 7) ? 7 : e - 1)) begin
                errors++; $display("FAIL sat_count[%0d]: got %0d need %0d", e, count_s[2:0], (e - 1 > 7) ? 7 : e - 1); end
        end
        checks++; if (count[7:0] !== 8'd9) begin errors++; $display("FAIL sat_wide_count: got %0d need 9", count[7:0]); end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            drive(2'(k), 8'(8'h50 + k));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL mid_full: got %b need 1111", out_valid); end
        out_ready = 4'b1111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_valid: got %b need 0000", out_valid); end
        checks++; if (count !== 32'h0 || count_s !== 12'h0) begin errors++; $display("FAIL mid_count: got %h/%h need 0/0", count, count_s); end
        tick();
        checks++; if (count !== 32'h0 || out_valid !== 4'b0000) begin
            errors++; $display("FAIL mid_after: got %h/%b need 0/0000", count, out_valid); end
        out_ready = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
        in_data = 8'h00; addr0 = 1'b0; addr1 = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_independent();
        test_streaming();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stream_demux4
`default_nettype wire
